// File: rtl/backtrack_fifo_lanes_response_dispatch_pkg.sv
// Shared packet, route and FIFO-status types for the lane-side response dispatcher.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a; prog_full in FIFOStateSignalsOutput is the backtrack signal.
package backtrack_fifo_lanes_response_dispatch_pkg;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } MemoryPacket;

    typedef struct packed {
        logic [ID_W-1:0] id_cu;
        logic [ID_W-1:0] id_bundle;
        logic [ID_W-1:0] id_lane;
        logic [ID_W-1:0] id_engine;
        logic [ID_W-1:0] id_module;
    } MemoryPacketArbitrate;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
        logic valid;
    } FIFOStateSignalsOutput;

    // One-hot id of the bundle after id_bundle, wrapping at num_bundles.
    function automatic logic [ID_W-1:0] next_bundle_onehot(input int id_bundle, input int num_bundles);
        logic [ID_W-1:0] onehot;
        onehot = '0;
        onehot[(id_bundle + 1) % num_bundles] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/backtrack_fifo_lanes_response_dispatch_lane_response_fifo.sv
// Per-lane response buffer: circular store with registered status and read data.
// Latency: write visible (empty low) 1 cycle after the write edge; read data 1 cycle after rd_en.
// Backpressure: prog_full/full published to the dispatcher; writes when full only accepted alongside a read.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en, rd_data (valid-qualified), status.
module lane_response_fifo
    import backtrack_fifo_lanes_response_dispatch_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int PROG_THRESHOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  MemoryPacket           wr_data,
    input  logic                  rd_en,
    output MemoryPacket           rd_data,
    output FIFOStateSignalsOutput status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    MemoryPacket           mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    MemoryPacket           rd_data_q, rd_data_d;
    FIFOStateSignalsOutput status_q, status_d;
    logic                  do_rd, do_wr;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        // Full is tolerated when a read frees the slot in the same cycle.
        do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rd_data_d = '0;
        if (do_rd) begin
            rd_data_d       = mem_q[rd_ptr_q];
            rd_data_d.valid = 1'b1;
        end
        // Status is computed from the post-update count so it tracks this cycle's traffic.
        status_d.empty     = (count_d == '0);
        status_d.full      = (count_d == CNT_W'(DEPTH));
        status_d.prog_full = (count_d >= CNT_W'(PROG_THRESHOLD));
        status_d.valid     = do_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            status_q  <= '{full: 1'b0, empty: 1'b1, prog_full: 1'b0, valid: 1'b0};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            status_q  <= status_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign status  = status_q;

endmodule

// File: rtl/backtrack_fifo_lanes_response_dispatch.sv
// Lane-side response dispatch: registers engine responses and broadcasts each to the routed lane buffers.
// Latency: response_in at t is written at the edge ending t+1, readable from t+2; read data 1 cycle after rd_en.
// Backpressure: per-lane prog_full backtracks the engine; a packet hitting a full, unread lane is dropped whole and flags overflow_error.
// Ports: ap_clk, areset (sync, active-high), route config, response_in, per-lane rd_en in, per-lane data/status out, overflow_error.
module backtrack_fifo_lanes_response_dispatch
    import backtrack_fifo_lanes_response_dispatch_pkg::*;
#(
    parameter int ID_CU           = 0,
    parameter int ID_BUNDLE       = 0,
    parameter int ID_LANE         = 0,
    parameter int ID_ENGINE       = 0,
    parameter int ID_MODULE       = 0,
    parameter int NUM_LANES_MAX   = 4,
    parameter int NUM_BUNDLES_MAX = 4,
    parameter int LANE_FIFO_DEPTH = 16,
    parameter int PROG_THRESHOLD  = 8
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  configure_route_valid,
    input  MemoryPacketArbitrate  configure_route_in,
    input  MemoryPacket           response_in,
    input  FIFOStateSignalsInput  fifo_response_lanes_signals_in [NUM_LANES_MAX],
    output MemoryPacket           response_lanes_out [NUM_LANES_MAX],
    output FIFOStateSignalsOutput fifo_response_lanes_backtrack_signals_out [NUM_LANES_MAX],
    output logic                  overflow_error
);

    if ((LANE_FIFO_DEPTH - PROG_THRESHOLD) < 6) begin : g_bad_threshold
        $error("LANE_FIFO_DEPTH - PROG_THRESHOLD must be at least 6 to absorb in-flight packets");
    end
    if (NUM_LANES_MAX < 2) begin : g_bad_lanes
        $error("NUM_LANES_MAX must be at least 2");
    end
    if ((1 << $clog2(LANE_FIFO_DEPTH)) != LANE_FIFO_DEPTH) begin : g_bad_depth
        $error("LANE_FIFO_DEPTH must be a power of 2");
    end

    localparam logic [ID_W-1:0] NEXT_BUNDLE = next_bundle_onehot(ID_BUNDLE, NUM_BUNDLES_MAX);

    logic                  areset_dispatch_q, areset_dispatch_d;
    MemoryPacketArbitrate  route_q, route_d;
    logic                  route_valid_q, route_valid_d;
    MemoryPacket           response_in_reg_q, response_in_reg_d;
    logic                  overflow_q, overflow_d;
    logic [NUM_LANES_MAX-1:0] mask, lane_full, lane_rd, lane_wr_en;
    logic                  blocked, pkt_vld;
    FIFOStateSignalsOutput lane_status [NUM_LANES_MAX];

    always_comb begin
        areset_dispatch_d = areset;
        route_d           = configure_route_valid ? configure_route_in : route_q;
        route_valid_d     = route_valid_q | configure_route_valid;
        response_in_reg_d = response_in;

        // Packets for the next bundle go to the lower lanes; anything else
        // leaves through the top lane toward the following bundle.
        mask = '0;
        if (route_valid_q) begin
            if (route_q.id_bundle[NUM_BUNDLES_MAX-1:0] == NEXT_BUNDLE[NUM_BUNDLES_MAX-1:0]) begin
                mask = {1'b0, route_q.id_lane[NUM_LANES_MAX-2:0]};
            end else begin
                mask[NUM_LANES_MAX-1] = route_q.id_lane[NUM_LANES_MAX-1];
            end
        end

        // All-or-none broadcast: one blocked target stops the write to every lane.
        pkt_vld    = response_in_reg_q.valid;
        blocked    = |(mask & lane_full & ~lane_rd);
        lane_wr_en = (pkt_vld && !blocked) ? mask : '0;
        overflow_d = overflow_q | (pkt_vld & blocked);
    end

    always_ff @(posedge ap_clk) begin
        areset_dispatch_q <= areset_dispatch_d;
    end

    always_ff @(posedge ap_clk) begin
        if (areset_dispatch_q) begin
            route_q           <= '0;
            route_valid_q     <= 1'b0;
            response_in_reg_q <= '0;
            overflow_q        <= 1'b0;
        end else begin
            route_q           <= route_d;
            route_valid_q     <= route_valid_d;
            response_in_reg_q <= response_in_reg_d;
            overflow_q        <= overflow_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES_MAX; i++) begin : g_lane
        assign lane_full[i] = lane_status[i].full;
        assign lane_rd[i]   = fifo_response_lanes_signals_in[i].rd_en;

        lane_response_fifo #(
            .DEPTH         (LANE_FIFO_DEPTH),
            .PROG_THRESHOLD(PROG_THRESHOLD)
        ) u_fifo (
            .clk    (ap_clk),
            .rst    (areset_dispatch_q),
            .wr_en  (lane_wr_en[i]),
            .wr_data(response_in_reg_q),
            .rd_en  (lane_rd[i]),
            .rd_data(response_lanes_out[i]),
            .status (lane_status[i])
        );

        assign fifo_response_lanes_backtrack_signals_out[i] = lane_status[i];
    end

    assign overflow_error = overflow_q;

    // Position ids and route fields other than bundle/lane carry no behaviour here.
    logic unused_ids;
    assign unused_ids = ^{route_q, 32'(ID_CU), 32'(ID_LANE), 32'(ID_ENGINE), 32'(ID_MODULE)};

endmodule

// File: tb/tb_backtrack_fifo_lanes_response_dispatch.sv
module tb_backtrack_fifo_lanes_response_dispatch;
    import backtrack_fifo_lanes_response_dispatch_pkg::*;

    localparam int NL = 4;

    logic                  ap_clk = 1'b0;
    logic                  areset;
    logic                  configure_route_valid;
    MemoryPacketArbitrate  configure_route_in;
    MemoryPacket           response_in;
    FIFOStateSignalsInput  rd_sig [NL];
    MemoryPacket           out0 [NL];
    MemoryPacket           out3 [NL];
    FIFOStateSignalsOutput bt0 [NL];
    FIFOStateSignalsOutput bt3 [NL];
    logic                  ovf0, ovf3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    backtrack_fifo_lanes_response_dispatch #(.ID_BUNDLE(0)) dut0 (
        .ap_clk                                   (ap_clk),
        .areset                                   (areset),
        .configure_route_valid                    (configure_route_valid),
        .configure_route_in                       (configure_route_in),
        .response_in                              (response_in),
        .fifo_response_lanes_signals_in           (rd_sig),
        .response_lanes_out                       (out0),
        .fifo_response_lanes_backtrack_signals_out(bt0),
        .overflow_error                           (ovf0)
    );

    backtrack_fifo_lanes_response_dispatch #(.ID_BUNDLE(3)) dut3 (
        .ap_clk                                   (ap_clk),
        .areset                                   (areset),
        .configure_route_valid                    (configure_route_valid),
        .configure_route_in                       (configure_route_in),
        .response_in                              (response_in),
        .fifo_response_lanes_signals_in           (rd_sig),
        .response_lanes_out                       (out3),
        .fifo_response_lanes_backtrack_signals_out(bt3),
        .overflow_error                           (ovf3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        response_in = '0;
        tick();
    endtask

    task automatic cfg(input logic [7:0] bundle, input logic [7:0] lane);
        configure_route_valid        = 1'b1;
        configure_route_in           = '0;
        configure_route_in.id_bundle = bundle;
        configure_route_in.id_lane   = lane;
        tick();
        configure_route_valid = 1'b0;
    endtask

    // One packet; returns once its write is visible in the lane status.
    task automatic send(input logic [31:0] d);
        response_in.valid   = 1'b1;
        response_in.address = {16'h0, d[15:0]};
        response_in.data    = d;
        tick();
        response_in.valid = 1'b0;
        tick();
    endtask

    // Expected lane emptiness given as a 4-bit vector (bit i = lane i empty).
    task automatic check_empty0(input string tag, input logic [3:0] exp);
        for (int i = 0; i < NL; i++) check($sformatf("%s_dut0_l%0d", tag, i), bt0[i].empty, exp[i]);
    endtask

    task automatic check_empty3(input string tag, input logic [3:0] exp);
        for (int i = 0; i < NL; i++) check($sformatf("%s_dut3_l%0d", tag, i), bt3[i].empty, exp[i]);
    endtask

    initial begin
        areset                = 1'b1;
        configure_route_valid = 1'b0;
        configure_route_in    = '0;
        response_in           = '0;
        for (int i = 0; i < NL; i++) rd_sig[i] = '0;

        // Reset values
        do_reset();
        for (int i = 0; i < NL; i++) begin
            check($sformatf("rst_empty_l%0d", i), bt0[i].empty, 1'b1);
            check($sformatf("rst_full_l%0d", i), bt0[i].full, 1'b0);
            check($sformatf("rst_pfull_l%0d", i), bt0[i].prog_full, 1'b0);
            check($sformatf("rst_btvalid_l%0d", i), bt0[i].valid, 1'b0);
            check($sformatf("rst_out_l%0d", i), out0[i], '0);
        end
        check("rst_ovf", ovf0, 1'b0);

        // Same-bundle broadcast: dut0 next bundle 0010 matches -> lanes 0,2;
        // dut3 next bundle 0001 differs and id_lane[3]=0 -> sink.
        cfg(8'b0010, 8'b0101);
        send(32'hA5A5_0001);
        check_empty0("bcast", 4'b1010);
        check_empty3("bcast_sink", 4'b1111);
        rd_sig[0].rd_en = 1'b1;
        tick();
        rd_sig[0].rd_en = 1'b0;
        check("bcast_rd_valid", out0[0].valid, 1'b1);
        check("bcast_rd_data", out0[0].data, 32'hA5A5_0001);
        check("bcast_bt_valid", bt0[0].valid, 1'b1);
        check("bcast_l0_empty_after", bt0[0].empty, 1'b1);
        rd_sig[2].rd_en = 1'b1;
        tick();
        rd_sig[2].rd_en = 1'b0;
        check("bcast_l2_data", out0[2].data, 32'hA5A5_0001);
        check("bcast_l2_empty_after", bt0[2].empty, 1'b1);
        tick();
        check("bcast_valid_drops", out0[2].valid, 1'b0);
        check("bcast_ovf3", ovf3, 1'b0);

        // Other bundle, then next-bundle wrap for ID_BUNDLE=3
        do_reset();
        cfg(8'b0100, 8'b1001);
        send(32'h0000_0033);
        check_empty3("other", 4'b0111);
        cfg(8'b0001, 8'b0011);
        send(32'h0000_0044);
        check_empty3("wrap", 4'b0100);
        rd_sig[3].rd_en = 1'b1;
        tick();
        rd_sig[3].rd_en = 1'b0;
        check("other_l3_data", out3[3].data, 32'h0000_0033);
        check("other_l3_single", bt3[3].empty, 1'b1);

        // prog_full threshold on lane 1
        do_reset();
        cfg(8'b0010, 8'b0010);
        for (int k = 1; k <= 8; k++) begin
            send(32'h100 + k);
            check($sformatf("pfull_after_%0d", k), bt0[1].prog_full, (k >= 8) ? 1'b1 : 1'b0);
        end
        rd_sig[1].rd_en = 1'b1;
        tick();
        rd_sig[1].rd_en = 1'b0;
        check("pfull_drop_after_read", bt0[1].prog_full, 1'b0);
        check("pfull_read_data", out0[1].data, 32'h101);

        // Full boundary on lane 0
        do_reset();
        cfg(8'b0010, 8'b0001);
        for (int k = 0; k < 16; k++) begin
            response_in.valid = 1'b1;
            response_in.data  = k;
            tick();
        end
        response_in.valid = 1'b0;
        tick();
        check("full_at16", bt0[0].full, 1'b1);
        check("full_pfull", bt0[0].prog_full, 1'b1);
        check("full_no_ovf", ovf0, 1'b0);
        // write accepted when the full lane is read in the same cycle
        response_in.valid = 1'b1;
        response_in.data  = 32'd100;
        tick();
        response_in.valid = 1'b0;
        rd_sig[0].rd_en   = 1'b1;
        tick();
        rd_sig[0].rd_en   = 1'b0;
        check("full_rw_data", out0[0].data, 32'd0);
        check("full_rw_still_full", bt0[0].full, 1'b1);
        check("full_rw_no_ovf", ovf0, 1'b0);
        // write with no read is dropped and flagged
        send(32'd200);
        check("full_drop_ovf", ovf0, 1'b1);
        check("full_drop_full", bt0[0].full, 1'b1);
        rd_sig[0].rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("drain_%0d", k), out0[0].data, (k < 15) ? 32'(k + 1) : 32'd100);
        end
        rd_sig[0].rd_en = 1'b0;
        check("drain_empty", bt0[0].empty, 1'b1);
        check("ovf_sticky", ovf0, 1'b1);

        // Reset mid-operation with a packet in the input register
        do_reset();
        cfg(8'b0010, 8'b0100);
        for (int k = 0; k < 5; k++) send(32'h200 + k);
        check("mid_l2_loaded", bt0[2].empty, 1'b0);
        response_in.valid = 1'b1;
        response_in.data  = 32'h2FF;
        do_reset();
        check_empty0("mid_rst", 4'b1111);
        check("mid_rst_ovf", ovf0, 1'b0);
        send(32'h300);
        check_empty0("mid_noroute", 4'b1111);
        check("mid_noroute_ovf", ovf0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
